// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory between a cpu port and an ext port
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  state_t                state, state_d;
  logic                  owner, owner_d, last_owner, last_owner_d, win;
  logic [1:0]            gnt, gnt_d, rvalid, rvalid_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_d;
  // register state and every output except read data; reset abandons any access at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt        <= 2'b00;
      rvalid     <= 2'b00;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      gnt        <= gnt_d;
      rvalid     <= rvalid_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_data   <= mem_data_d;
    end
  // arbitration and transaction sequencing; mem_we doubles as the latched write flag during ACCESS
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    gnt_d        = 2'b00;
    rvalid_d     = 2'b00;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_data_d   = mem_data;
    win          = (req0 && req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_owner) : req1;
    if (state == IDLE && (req0 || req1)) begin
      state_d      = ACCESS;
      owner_d      = win;
      last_owner_d = win;
      gnt_d        = win ? 2'b10 : 2'b01;
      mem_we_d     = win ? we1 : we0;
      mem_addr_d   = win ? addr1 : addr0;
      mem_data_d   = win ? wdata1 : wdata0;
    end else if (state == ACCESS) begin
      state_d  = mem_we ? IDLE : RDATA;
      rvalid_d = mem_we ? 2'b00 : (owner ? 2'b10 : 2'b01);
    end else if (state == RDATA) begin
      state_d = IDLE;
    end
  end
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rvalid[0] ? mem_in : '0;
  assign rdata1  = rvalid[1] ? mem_in : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter against a synchronous-read memory model
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_data;
  logic [15:0] mem_in = '0;
  logic [5:0]  mem_addr;
  logic [15:0] mem [64];
  logic        req0f = 1'b0, req1f = 1'b0;
  logic        gnt0f, gnt1f, rvalid0f, rvalid1f, mem_wef;
  logic [15:0] rdata0f, rdata1f, mem_dataf;
  logic [5:0]  mem_addrf;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_in(mem_in), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data));

  mem_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .req0(req0f), .req1(req1f), .we0(1'b0), .we1(1'b0),
    .addr0(6'd7), .addr1(6'd8), .wdata0(16'h0), .wdata1(16'h0),
    .gnt0(gnt0f), .gnt1(gnt1f), .rvalid0(rvalid0f), .rvalid1(rvalid1f),
    .rdata0(rdata0f), .rdata1(rdata1f), .mem_in(16'h0), .mem_we(mem_wef),
    .mem_addr(mem_addrf), .mem_data(mem_dataf));

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    mem[5] = 16'h1234;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    #1;
    chk("reset_gnt", {gnt0, gnt1, rvalid0, rvalid1, mem_we}, 0);
    chk("reset_addr_data", {mem_addr, mem_data, rdata0, rdata1}, 0);
    step();
    step();
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    step();
    chk("rd0_gnt", {gnt0, gnt1, mem_we, mem_addr}, {3'b100, 6'd5});
    req0 = 1'b0;
    step();
    chk("rd0_rvalid", {gnt0, gnt1, rvalid0, rvalid1}, 4'b0010);
    chk("rd0_rdata", rdata0, 16'h1234);
    step();
    chk("rd0_idle", {gnt0, gnt1, rvalid0, rvalid1}, 0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd63; wdata1 = 16'hBEEF;
    step();
    chk("wr1_gnt", {gnt0, gnt1, mem_we, rvalid1}, 4'b0110);
    chk("wr1_bus", {mem_addr, mem_data}, {6'd63, 16'hBEEF});
    req1 = 1'b0;
    step();
    chk("wr1_end", {gnt1, mem_we, rvalid1, mem_addr}, {3'b000, 6'd63});
    req1 = 1'b1; we1 = 1'b0;
    step();
    chk("rb1_gnt", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    step();
    chk("rb1_rvalid", {rvalid0, rvalid1}, 2'b01);
    chk("rb1_rdata", rdata1, 16'hBEEF);
    step();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 6'd1; addr1 = 6'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_gnt%0d", i), {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
      chk($sformatf("rr_rvalid%0d", i), {rvalid0, rvalid1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("rr_rdata%0d", i), {rdata0, rdata1},
          (i % 2 == 0) ? {16'h1111, 16'h0} : {16'h0, 16'h2222});
      step();
      chk($sformatf("rr_idle%0d", i), {gnt0, gnt1, rvalid0, rvalid1}, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    req0f = 1'b1; req1f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fp_gnt%0d", i), {gnt0f, gnt1f, mem_addrf}, {2'b10, 6'd7});
      step();
      chk($sformatf("fp_rvalid%0d", i), {gnt0f, gnt1f, rvalid0f, rvalid1f}, 4'b0010);
      step();
    end
    req0f = 1'b0;
    step();
    chk("fp_gnt1_after_drop", {gnt0f, gnt1f, mem_addrf}, {2'b01, 6'd8});
    req1f = 1'b0;
    step();
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    step();
    chk("rst_pre_gnt", {gnt0, gnt1}, 2'b10);
    #1;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rst_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_data}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_no_rvalid_a", {gnt0, rvalid0, rvalid1}, 0);
    step();
    chk("rst_no_rvalid_b", {gnt0, rvalid0, rvalid1}, 0);
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'd1; addr1 = 6'd2;
    step();
    chk("rst_tie_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    req0 = 1'b1; we0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr0 = 6'(i); wdata0 = 16'(i);
      step();
      chk($sformatf("b2b_gnt%0d", i), {gnt0, mem_we, mem_addr, mem_data}, {2'b11, 6'(i), 16'(i)});
      step();
      chk($sformatf("b2b_gap%0d", i), {gnt0, mem_we}, 2'b00);
    end
    req0 = 1'b0; we0 = 1'b0;
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_mem%0d", i), mem[i], 16'(i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory (ADDR_WIDTH x DATA_WIDTH, synchronous read) between two requesters: port 0 = cpu, port 1 = ext (program loader / debug access).
- Sits between the requesters and the memory, and sequences each access as a grant/access/response transaction.
- Arbitrates round-robin by default, with an optional fixed cpu-priority mode.

Parameters:
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 16, memory word width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0 / req1  input  1  access request, port 0 / port 1
- we0 / we1  input  1  1 = write, 0 = read; valid while reqN high
- addr0 / addr1  input  ADDR_WIDTH  word address
- wdata0 / wdata1  input  DATA_WIDTH  write data
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted, memory access in progress
- rvalid0 / rvalid1  output  1  one-cycle pulse: read data valid on rdataN
- rdata0 / rdata1  output  DATA_WIDTH  read data
- mem_in  input  DATA_WIDTH  memory read data, valid the cycle after the address cycle
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_data  output  DATA_WIDTH  memory write data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=0, last_owner=1, so port 0 wins the first tie.
  - gnt0/1=0, rvalid0/1=0, mem_we=0, mem_addr=0, mem_data=0.
- All outputs except rdataN are registered. rdataN = mem_in whenever rvalidN=1, else 0.
- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise choose a winner:
    - only one req high: that port wins.
    - both high with FIXED_PRIO=1: port 0 wins.
    - both high with FIXED_PRIO=0: the port != last_owner wins.
  - On the clock edge, latch owner=winner and last_owner=winner. Load mem_addr, mem_data and mem_we from the winner's addr/wdata/we. Set gnt_winner=1. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Memory sees the address, plus the write if mem_we=1. gnt_owner=1.
  - On exit, clear gnt and mem_we. mem_addr/mem_data hold their values.
  - If the latched we=1, go to IDLE.
  - If the latched we=0, go to RDATA with rvalid_owner=1.
- RDATA (exactly 1 cycle):
  - rvalid_owner=1, rdata_owner=mem_in.
  - On exit, clear rvalid and go to IDLE.
- Latency and throughput:
  - Write: req sampled at edge t, gnt/mem_we in cycle t+1, new arbitration in cycle t+2. Minimum 2 cycles per write.
  - Read: gnt in cycle t+1, rvalid/rdata in cycle t+2. Minimum 3 cycles per read.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Drop req on the edge after gnt, unless issuing a new request.
  - A req still high in IDLE after a grant is treated as a new request.
- Arbiter guarantees:
  - Never grants both ports in the same cycle.
  - A losing request stays pending with no timeout.
  - In round-robin mode, with both reqs continuously high, grants alternate 0,1,0,1...
  - req/addr changes outside IDLE are ignored; the latched values are used.
- Reset mid-transaction (any state): the access is abandoned. No gnt or rvalid is produced afterwards. mem_we drops immediately (asynchronously). Arbitration restarts with last_owner=1.
- No wrap or width arithmetic is performed; addresses pass through unmodified.

Test Plan:
- Single read, port 0: memory[5]=16'h1234; req0=1, we0=0, addr0=5 -> gnt0 in next cycle with mem_addr=5, mem_we=0; rvalid0=1 and rdata0=16'h1234 one cycle later; gnt1/rvalid1 stay 0.
- Single write, port 1: req1=1, we1=1, addr1=63, wdata1=16'hBEEF -> gnt1 and mem_we=1 with mem_addr=63, mem_data=16'hBEEF for exactly one cycle; a later read of addr 63 returns 16'hBEEF.
- Simultaneous requests, FIXED_PRIO=0, both held for 4 transactions (reads of addr 1 from port 0, addr 2 from port 1) -> grant order 0,1,0,1; never gnt0 and gnt1 both high; each rvalid goes only to its owner.
- Simultaneous requests, FIXED_PRIO=1, port 0 re-requesting immediately after each gnt -> port 0 served every time, port 1 waits; port 1 is granted on the first IDLE in which req0=0.
- Reset mid-read: assert rst_n=0 during ACCESS of a port-0 read -> all outputs 0 immediately; no rvalid0 after release; the next tied request is granted to port 0.
- Back-to-back writes from port 0 to addr 0..3 with data 0..3 -> gnt0 every second cycle; memory holds 0,1,2,3.
